// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Purpose  : Shares one sram-like memory port between the instruction-fetch
//            and data requesters; fixed data>inst priority, one transaction
//            outstanding. Optional starvation guard: define ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction requester
    input  logic                i_inst_req,
    input  logic                i_inst_wr,
    input  logic [1:0]          i_inst_size,
    input  logic [DATA_W/8-1:0] i_inst_wstrb,
    input  logic [ADDR_W-1:0]   i_inst_addr,
    input  logic [DATA_W-1:0]   i_inst_wdata,
    output logic                o_inst_addr_ok,
    output logic                o_inst_data_ok,
    output logic [DATA_W-1:0]   o_inst_rdata,
    // data requester
    input  logic                i_data_req,
    input  logic                i_data_wr,
    input  logic [1:0]          i_data_size,
    input  logic [DATA_W/8-1:0] i_data_wstrb,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    output logic                o_data_addr_ok,
    output logic                o_data_data_ok,
    output logic [DATA_W-1:0]   o_data_rdata,
    // memory side
    output logic                o_mem_req,
    output logic                o_mem_wr,
    output logic [1:0]          o_mem_size,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_addr_ok,
    input  logic                i_mem_data_ok,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    if (STARVE_MAX < 1) begin : g_param_check
        $error("STARVE_MAX must be >= 1");
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic w_pick_inst;
    logic w_pick_data;
    logic w_arb_en;
    logic w_grant_inst;
    logic w_grant_data;

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_starved;

    assign w_starved   = i_inst_req && (r_starve_cnt == c_CNT_W'(STARVE_MAX));
    assign w_pick_inst = i_inst_req & (~i_data_req | w_starved);
    assign w_pick_data = i_data_req & ~w_starved;

    // Counts data wins over a waiting inst; cleared once inst is served or gives up.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_grant_inst || !i_inst_req)
                r_starve_cnt <= '0;
            else if (w_grant_data && (r_starve_cnt != c_CNT_W'(STARVE_MAX)))
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_pick_inst = i_inst_req & ~i_data_req;
    assign w_pick_data = i_data_req;
`endif

    // Reset gates the grants so addr_ok stays low while resetn is asserted.
    assign w_arb_en     = resetn && (r_state == c_IDLE);
    assign w_grant_inst = w_arb_en & w_pick_inst;
    assign w_grant_data = w_arb_en & w_pick_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_inst || w_grant_data) w_state_nxt = c_ADDR;
            c_ADDR:  if (i_mem_addr_ok)                w_state_nxt = c_DATA;
            c_DATA:  if (i_mem_data_ok)                w_state_nxt = c_IDLE;
            default:                                   w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        o_inst_addr_ok = w_grant_inst;
        o_data_addr_ok = w_grant_data;
        o_mem_req      = (r_state == c_ADDR);
        o_busy         = (r_state != c_IDLE);
        o_inst_data_ok = (r_state == c_DATA) && i_mem_data_ok && !r_owner;
        o_data_data_ok = (r_state == c_DATA) && i_mem_data_ok &&  r_owner;
        o_inst_rdata   = o_inst_data_ok ? i_mem_rdata : '0;
        o_data_rdata   = o_data_data_ok ? i_mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner <= 1'b1;
            r_wr    <= i_data_wr;
            r_size  <= i_data_size;
            r_wstrb <= i_data_wstrb;
            r_addr  <= i_data_addr;
            r_wdata <= i_data_wdata;
        end else if (w_grant_inst) begin
            r_owner <= 1'b0;
            r_wr    <= i_inst_wr;
            r_size  <= i_inst_size;
            r_wstrb <= i_inst_wstrb;
            r_addr  <= i_inst_addr;
            r_wdata <= i_inst_wdata;
        end
    end

    assign o_mem_wr    = r_wr;
    assign o_mem_size  = r_size;
    assign o_mem_wstrb = r_wstrb;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_arbiter
// Purpose  : Directed vector table plus hand-written reset and arbitration
//            sequences for sram_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_SMAX = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            inst_req, data_req;
    logic            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [c_DW-1:0] inst_rdata, data_rdata;
    logic            mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
    logic [1:0]      mem_size;
    logic [3:0]      mem_wstrb;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata, mem_rdata;

    // Fixed requester payloads
    localparam logic [31:0] c_I_ADDR  = 32'h1c00_0000;
    localparam logic [31:0] c_I_WDATA = 32'h1111_2222;
    localparam logic [31:0] c_D_ADDR  = 32'h0000_1000;
    localparam logic [31:0] c_D_WDATA = 32'h0000_1234;

    always #5 clk = ~clk;

    sram_req_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .STARVE_MAX(c_SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_inst_req(inst_req), .i_inst_wr(1'b0), .i_inst_size(2'd2), .i_inst_wstrb(4'h0),
        .i_inst_addr(c_I_ADDR), .i_inst_wdata(c_I_WDATA),
        .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
        .i_data_req(data_req), .i_data_wr(1'b1), .i_data_size(2'd1), .i_data_wstrb(4'h3),
        .i_data_addr(c_D_ADDR), .i_data_wdata(c_D_WDATA),
        .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
        .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_size(mem_size), .o_mem_wstrb(mem_wstrb),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_addr_ok(mem_addr_ok), .i_mem_data_ok(mem_data_ok), .i_mem_rdata(mem_rdata),
        .o_busy(busy)
    );

    // flags = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy}
    // cap   = captured payload expected on mem_*: 0 none, 1 inst, 2 data, -1 don't check
    typedef struct {
        logic        rstn, ireq, dreq, maok, mdok;
        logic [31:0] rdata;
        logic [5:0]  flags;
        logic [31:0] irdata, drdata;
        int          cap;
    } vec_t;

    vec_t vecs[23];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [5:0] ef,
                         input logic [31:0] eir, input logic [31:0] edr, input int cap);
        logic [5:0]  gf;
        logic [31:0] ea, ew;
        logic        ewr;
        logic [1:0]  es;
        logic [3:0]  eb;
        logic        bad;
        gf = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy};
        case (cap)
            1:       begin ea = c_I_ADDR; ew = c_I_WDATA; ewr = 1'b0; es = 2'd2; eb = 4'h0; end
            2:       begin ea = c_D_ADDR; ew = c_D_WDATA; ewr = 1'b1; es = 2'd1; eb = 4'h3; end
            default: begin ea = '0;       ew = '0;       ewr = 1'b0; es = 2'd0; eb = 4'h0; end
        endcase
        bad = (gf !== ef) || (inst_rdata !== eir) || (data_rdata !== edr);
        if (cap >= 0)
            bad = bad || (mem_addr !== ea) || (mem_wdata !== ew) || (mem_wr !== ewr)
                      || (mem_size !== es) || (mem_wstrb !== eb);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got flags=%b irdata=%h drdata=%h addr=%h wr=%b size=%0d wstrb=%h wdata=%h; want flags=%b irdata=%h drdata=%h cap=%0d",
                     name, gf, inst_rdata, data_rdata, mem_addr, mem_wr, mem_size, mem_wstrb,
                     mem_wdata, ef, eir, edr, cap);
        end
    endtask

    task automatic drive(input logic rn, input logic ir, input logic dr,
                         input logic ma, input logic md, input logic [31:0] rd);
        resetn = rn; inst_req = ir; data_req = dr;
        mem_addr_ok = ma; mem_data_ok = md; mem_rdata = rd;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        //            rstn ireq dreq maok mdok rdata          flags      irdata        drdata        cap
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0,        32'h0,        0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b100000, 32'h0,        32'h0,        0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 6'b001001, 32'hDEADBEEF, 32'h0,        1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0,        32'h0,        1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b010000, 32'h0,        32'h0,        1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        2};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00C0FFEE, 6'b000101, 32'h0,        32'h00C0FFEE, 2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b100000, 32'h0,        32'h0,        2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h99,       6'b000011, 32'h0,        32'h0,        1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 6'b001001, 32'hA5A5A5A5, 32'h0,        1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000000, 32'h0,        32'h0,        1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77,       6'b000000, 32'h0,        32'h0,        1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b010000, 32'h0,        32'h0,        1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000011, 32'h0,        32'h0,        2};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b000001, 32'h0,        32'h0,        2};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12,       6'b000101, 32'h0,        32'h12,       2};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 32'h0,        32'h0,        2};

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].rstn, vecs[i].ireq, vecs[i].dreq, vecs[i].maok, vecs[i].mdok, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].irdata, vecs[i].drdata, vecs[i].cap);
        end

        // Async reset while a transaction sits in DATA
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1; check("rst_seq_accept", 6'b100000, '0, '0, 2);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1; check("rst_seq_in_data", 6'b000001, '0, '0, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF0000);
        #1; check("rst_seq_outputs_zero", 6'b000000, '0, '0, 0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1; check("rst_seq_accept_after", 6'b100000, '0, '0, 0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
        #1; check("rst_seq_complete", 6'b001001, 32'h5, '0, 1);

        // Both requesters held, memory answers every cycle: one grant per 3 cycles
        begin
            int  cnt;
            bit  exp_inst;
            cnt = 0;
            exp_inst = 1'b0;
            @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0BAD_F00D);
            for (int k = 0; k < 18; k++) begin
                #1;
                if (k % 3 == 0) begin
`ifdef ARB_STARVE_GUARD_EN
                    exp_inst = (cnt == c_SMAX);
`else
                    exp_inst = 1'b0;
`endif
                    if (exp_inst) cnt = 0;
                    else if (cnt < c_SMAX) cnt++;
                    check($sformatf("hold_grant%0d", k / 3),
                          exp_inst ? 6'b100000 : 6'b010000, '0, '0, -1);
                end else if (k % 3 == 2) begin
                    check($sformatf("hold_resp%0d", k / 3),
                          exp_inst ? 6'b001001 : 6'b000101,
                          exp_inst ? 32'h0BAD_F00D : 32'h0,
                          exp_inst ? 32'h0 : 32'h0BAD_F00D, exp_inst ? 1 : 2);
                end
                @(negedge clk);
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
